hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage RV32I core. Sits in decode, alongside the operand-forwarding stage: it covers what forwarding cannot resolve. It detects load-use hazards, taken-branch redirects and data-memory wait states, then drives the stall, flush and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also runs a data-memory watchdog that releases a hung access and flags the error.

## Interface
Parameters:
- MEM_TIMEOUT, 16 — maximum consecutive memory-wait cycles before the watchdog fires; legal range 1..255.

Ports:
- clock  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr1DEC, addr2DEC  in  5  source register addresses of the instruction in decode.
- use1DEC, use2DEC  in  1  the decode instruction actually reads rs1 / rs2.
- rdEXE  in  5  destination register of the instruction in execute.
- WregEXE  in  1  the execute instruction writes rdEXE.
- loadEXE  in  1  the execute instruction is a load.
- branchTakenEXE  in  1  execute resolved a taken branch or jump.
- memReqMEM  in  1  the memory-stage instruction is accessing data memory.
- memReadyMEM  in  1  data memory completes the access this cycle.
- stallPC, stallFD, stallDE, stallEM  out  1  hold the PC and each pipeline register.
- flushFD  out  1  clear IF/ID to a NOP.
- bubbleDE  out  1  load a NOP into ID/EX.
- bubbleMW  out  1  load a NOP into MEM/WB.
- memErr  out  1  sticky watchdog error flag.
- perfLoadUse, perfMemWait, perfFlush  out  32  performance counters (present only with HAZARD_PERF_EN).

## Operation
- Load-use hazard:
  - `lu = loadEXE & WregEXE & rdEXE!=0 & ((use1DEC & rdEXE==addr1DEC) | (use2DEC & rdEXE==addr2DEC))`.
  - Response: stallPC=1, stallFD=1, bubbleDE=1.
- Branch redirect: branchTakenEXE → flushFD=1, bubbleDE=1. The branch overrides any simultaneous load-use condition.
- Memory wait:
  - `freeze = memReqMEM & ~memReadyMEM & ~tmo`.
  - Response: stallPC, stallFD, stallDE, stallEM = 1 and bubbleMW=1.
  - Load-use and branch responses are suppressed while frozen; they re-evaluate after release.
- Priority: freeze > branch > load-use.
- FSM states RUN and WAIT, with an 8-bit counter cnt:
  - RUN: if memReqMEM & ~memReadyMEM → WAIT, cnt←1.
  - WAIT, memReadyMEM=1 → RUN, cnt←0.
  - WAIT, cnt==MEM_TIMEOUT → tmo=1 (combinational), freeze drops this cycle, memErr←1, → RUN, cnt←0.
  - WAIT, otherwise → cnt←cnt+1.
- memErr is cleared only by reset.

## Timing
- All control outputs are combinational from the current state and inputs, valid in the same cycle.
- A load-use stall lasts exactly 1 cycle: the next cycle rdEXE holds the bubble (WregEXE=0).
- A memory wait freezes for N cycles, where N = number of cycles with memReadyMEM low, N ≤ MEM_TIMEOUT. On timeout the pipeline advances on cycle MEM_TIMEOUT+1 of the access.
- While reset=1: all outputs 0. On the next edge: state=RUN, cnt=0, memErr=0, counters=0.
- Reset asserted mid-WAIT aborts the wait immediately; no memErr is set.
- A memReqMEM deassertion while in WAIT is treated as ready.

## Configuration
- HAZARD_PERF_EN defined:
  - The perf* ports and counters exist.
  - perfLoadUse increments on each cycle that applies a load-use stall.
  - perfMemWait increments on each freeze cycle.
  - perfFlush increments on each applied branch flush.
  - All three saturate at 0xFFFFFFFF.
- HAZARD_PERF_EN undefined: the perf* ports and counters are absent; all other behaviour is identical.

## Test plan
- Load-use: loadEXE=1, WregEXE=1, rdEXE=5, addr2DEC=5, use2DEC=1 → stallPC/stallFD/bubbleDE=1 for 1 cycle; perfLoadUse=1.
- rd=x0 and unused source: rdEXE=0 matching addr1DEC, and separately rdEXE=7=addr1DEC with use1DEC=0 → no stall.
- Branch with simultaneous load-use hazard → flushFD=1, bubbleDE=1, stallPC=0.
- Memory wait: memReqMEM=1, memReadyMEM low for 3 cycles then high → freeze for 3 cycles, released on the 4th; perfMemWait=3; memErr=0.
- Watchdog: MEM_TIMEOUT=4, memReadyMEM held low → freeze for 4 cycles, released on the 5th, memErr=1 from the next edge and held until reset.
- Reset asserted in WAIT after 2 cycles → all outputs 0; after release, state=RUN and memErr=0.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait freeze with watchdog.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_unit #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  addr1DEC,
  input  logic [4:0]  addr2DEC,
  input  logic        use1DEC,
  input  logic        use2DEC,
  input  logic [4:0]  rdEXE,
  input  logic        WregEXE,
  input  logic        loadEXE,
  input  logic        branchTakenEXE,
  input  logic        memReqMEM,
  input  logic        memReadyMEM,
  output logic        stallPC,
  output logic        stallFD,
  output logic        stallDE,
  output logic        stallEM,
  output logic        flushFD,
  output logic        bubbleDE,
  output logic        bubbleMW,
`ifdef HAZARD_PERF_EN
  output logic [31:0] perfLoadUse,
  output logic [31:0] perfMemWait,
  output logic [31:0] perfFlush,
`endif
  output logic        memErr
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [7:0] TMO  = 8'(MEM_TIMEOUT);

  logic [0:0] state;
  logic [7:0] cnt;
  logic       err;
  logic       lu, tmo, freeze, br_app, lu_app;

  always_comb begin
    lu = loadEXE & WregEXE & (rdEXE != 5'd0) &
         ((use1DEC & (rdEXE == addr1DEC)) | (use2DEC & (rdEXE == addr2DEC)));
    tmo    = (state == WAIT) & (cnt == TMO);
    freeze = ~reset & memReqMEM & ~memReadyMEM & ~tmo;
    br_app = ~reset & ~freeze & branchTakenEXE;
    lu_app = ~reset & ~freeze & ~branchTakenEXE & lu;
  end

  always_comb begin
    stallPC  = freeze | lu_app;
    stallFD  = freeze | lu_app;
    stallDE  = freeze;
    stallEM  = freeze;
    bubbleMW = freeze;
    flushFD  = br_app;
    bubbleDE = br_app | lu_app;
    memErr   = err & ~reset;
  end

  // A dropped request in WAIT is treated the same as a completed access.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (memReqMEM & ~memReadyMEM) begin
            state <= WAIT;
            cnt   <= 8'd1;
          end
        end
        default: begin
          if (~memReqMEM | memReadyMEM) begin
            state <= RUN;
            cnt   <= '0;
          end else if (tmo) begin
            state <= RUN;
            cnt   <= '0;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] c_lu, c_mw, c_fl;

  always_ff @(posedge clock) begin
    if (reset) begin
      c_lu <= '0;
      c_mw <= '0;
      c_fl <= '0;
    end else begin
      if (lu_app && c_lu != '1) c_lu <= c_lu + 32'd1;
      if (freeze && c_mw != '1) c_mw <= c_mw + 32'd1;
      if (br_app && c_fl != '1) c_fl <= c_fl + 32'd1;
    end
  end

  always_comb begin
    perfLoadUse = reset ? '0 : c_lu;
    perfMemWait = reset ? '0 : c_mw;
    perfFlush   = reset ? '0 : c_fl;
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with MEM_TIMEOUT=4; perf checks only under HAZARD_PERF_EN.
module tb_hazard_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] addr1DEC, addr2DEC, rdEXE;
  logic       use1DEC, use2DEC, WregEXE, loadEXE, branchTakenEXE;
  logic       memReqMEM, memReadyMEM;
  logic       stallPC, stallFD, stallDE, stallEM, flushFD, bubbleDE, bubbleMW, memErr;
`ifdef HAZARD_PERF_EN
  logic [31:0] perfLoadUse, perfMemWait, perfFlush;
`endif

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clock = ~clock;

  hazard_unit #(.MEM_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .addr1DEC(addr1DEC), .addr2DEC(addr2DEC),
    .use1DEC(use1DEC), .use2DEC(use2DEC),
    .rdEXE(rdEXE), .WregEXE(WregEXE), .loadEXE(loadEXE),
    .branchTakenEXE(branchTakenEXE),
    .memReqMEM(memReqMEM), .memReadyMEM(memReadyMEM),
    .stallPC(stallPC), .stallFD(stallFD), .stallDE(stallDE), .stallEM(stallEM),
    .flushFD(flushFD), .bubbleDE(bubbleDE), .bubbleMW(bubbleMW),
`ifdef HAZARD_PERF_EN
    .perfLoadUse(perfLoadUse), .perfMemWait(perfMemWait), .perfFlush(perfFlush),
`endif
    .memErr(memErr)
  );

  // {stallPC,stallFD,stallDE,stallEM,flushFD,bubbleDE,bubbleMW,memErr}
  logic [7:0] ctl;
  assign ctl = {stallPC, stallFD, stallDE, stallEM, flushFD, bubbleDE, bubbleMW, memErr};

  localparam logic [7:0] IDLE   = 8'b0000_0000;
  localparam logic [7:0] LUSE   = 8'b1100_0100;
  localparam logic [7:0] FLUSH  = 8'b0000_1100;
  localparam logic [7:0] FREEZE = 8'b1111_0010;
  localparam logic [7:0] ERR    = 8'b0000_0001;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    addr1DEC = '0; addr2DEC = '0; rdEXE = '0;
    use1DEC = 0; use2DEC = 0; WregEXE = 0; loadEXE = 0; branchTakenEXE = 0;
    memReqMEM = 0; memReadyMEM = 0;
  endtask

  task automatic set_lu();
    loadEXE = 1; WregEXE = 1; rdEXE = 5'd5; addr2DEC = 5'd5; use2DEC = 1;
  endtask

  initial begin
    clear_in();
    reset = 1;
    set_lu();
    memReqMEM = 1;
    tick();
    #1 check("reset_outputs", {24'd0, ctl}, {24'd0, IDLE});

    tick();
    reset = 0;
    clear_in();
    #1 check("idle", {24'd0, ctl}, {24'd0, IDLE});
`ifdef HAZARD_PERF_EN
    check("perf_reset", perfMemWait, 32'd0);
`endif

    // load-use stall, one cycle
    tick(); set_lu();
    #1 check("load_use", {24'd0, ctl}, {24'd0, LUSE});
    tick(); WregEXE = 0;
    #1 check("load_use_bubble", {24'd0, ctl}, {24'd0, IDLE});
`ifdef HAZARD_PERF_EN
    check("perf_load_use", perfLoadUse, 32'd1);
`endif

    // rd = x0 never stalls
    tick(); clear_in(); loadEXE = 1; WregEXE = 1; rdEXE = 5'd0; addr1DEC = 5'd0; use1DEC = 1;
    #1 check("rd_x0", {24'd0, ctl}, {24'd0, IDLE});
    // matching but unused source
    tick(); rdEXE = 5'd7; addr1DEC = 5'd7; use1DEC = 0;
    #1 check("unused_src", {24'd0, ctl}, {24'd0, IDLE});
    tick(); use1DEC = 1;
    #1 check("rs1_hazard", {24'd0, ctl}, {24'd0, LUSE});

    // branch overrides load-use
    tick(); clear_in(); set_lu(); branchTakenEXE = 1;
    #1 check("branch_over_lu", {24'd0, ctl}, {24'd0, FLUSH});
`ifdef HAZARD_PERF_EN
    tick(); clear_in();
    #1 check("perf_flush", perfFlush, 32'd1);
    check("perf_lu_after_branch", perfLoadUse, 32'd2);
`endif

    // memory wait: 3 not-ready cycles then ready
    tick(); clear_in(); memReqMEM = 1;
    #1 check("wait_c1", {24'd0, ctl}, {24'd0, FREEZE});
    tick(); branchTakenEXE = 1;
    #1 check("wait_c2_branch_suppressed", {24'd0, ctl}, {24'd0, FREEZE});
    tick(); branchTakenEXE = 0;
    #1 check("wait_c3", {24'd0, ctl}, {24'd0, FREEZE});
    tick(); memReadyMEM = 1;
    #1 check("wait_release", {24'd0, ctl}, {24'd0, IDLE});
    tick(); clear_in();
    #1 check("wait_no_err", {24'd0, ctl}, {24'd0, IDLE});
`ifdef HAZARD_PERF_EN
    check("perf_mem_wait", perfMemWait, 32'd3);
`endif

    // watchdog: MEM_TIMEOUT=4
    memReqMEM = 1;
    for (int i = 1; i <= 4; i++) begin
      #1 check($sformatf("wd_freeze_%0d", i), {24'd0, ctl}, {24'd0, FREEZE});
      tick();
    end
    #1 check("wd_release", {24'd0, ctl}, {24'd0, IDLE});
    tick(); memReqMEM = 0;
    #1 check("wd_err_set", {24'd0, ctl}, {24'd0, ERR});
    tick();
    #1 check("wd_err_sticky", {24'd0, ctl}, {24'd0, ERR});
`ifdef HAZARD_PERF_EN
    check("perf_mem_wait_wd", perfMemWait, 32'd7);
`endif

    // reset during WAIT
    memReqMEM = 1;
    #1 check("rw_c1", {24'd0, ctl}, {24'd0, FREEZE | ERR});
    tick();
    #1 check("rw_c2", {24'd0, ctl}, {24'd0, FREEZE | ERR});
    tick(); reset = 1;
    #1 check("rw_reset_outputs", {24'd0, ctl}, {24'd0, IDLE});
    tick(); reset = 0; memReqMEM = 0;
    #1 check("rw_after_reset", {24'd0, ctl}, {24'd0, IDLE});
    // fresh wait must see full budget again from RUN
    memReqMEM = 1;
    for (int i = 1; i <= 4; i++) begin
      #1 check($sformatf("rw_freeze_%0d", i), {24'd0, ctl}, {24'd0, FREEZE});
      tick();
    end
    #1 check("rw_timeout_release", {24'd0, ctl}, {24'd0, IDLE});
`ifdef HAZARD_PERF_EN
    check("perf_after_reset", perfMemWait, 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
